// File: rtl/super_pkg.sv
// Shared load/store pipeline types.
// Provides the decoded LSU request record, its idle value, and the
// state encoding and default credit depth used by ls_req_arbiter.
package super_pkg;

  // Decoded load/store request as presented to lsu_if.
  typedef struct packed {
    logic        is_store;
    logic        sign_ext;
    logic [1:0]  size;
    logic [4:0]  rd;
    logic [31:0] addr;
  } lsu_req_info_t;

  localparam lsu_req_info_t NULL_LSU_REQ_INFO = '0;

  // ARB: free arbitration; LOCK: a multi-beat complex sequence owns the slot.
  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } lsarb_state_e;

  localparam int unsigned LSARB_MAX_OUTST = 8;

endpackage

// File: rtl/ls_req_arbiter_credit_counter.sv
// credit_counter: saturating up/down counter with a sticky underflow flag.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   clr_i          return the count to zero (takes priority over inc/dec)
//   inc_i, dec_i   count up / down; both together leave the count unchanged
//   cnt_o          current count, 0..MaxVal
//   err_o          set by a decrement at zero, cleared only by reset
module credit_counter #(
  parameter int unsigned MaxVal = 8,
  localparam int unsigned CntW  = $clog2(MaxVal + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o,
  output logic            err_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(MaxVal);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clr_i) begin
      // A decrement in the clear cycle is dropped and cannot raise the flag.
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;

endmodule

// File: rtl/ls_req_arbiter.sv
// ls_req_arbiter: shares the single LSU request slot between the issuer and
// the complex-instruction unit, keeps locked complex sequences atomic, bounds
// issuer starvation, and caps in-flight requests with a credit counter.
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   flush_i                       pipeline flush
//   iss_valid_i/iss_req_i/iss_rdy_o          issuer request channel
//   cx_valid_i/cx_lock_i/cx_req_i/cx_rdy_o   complex-unit request channel
//   lsif_valid_o/lsif_req_o/lsif_rdy_i       request to lsu_if
//   retire_i                      one LSU response consumed by commit
//   grant_cx_o                    current selection is the complex unit
//   outst_o                       in-flight request count
//   cnt_err_o                     sticky retire-underflow flag
module ls_req_arbiter
  import super_pkg::*;
#(
  parameter int unsigned MaxOutst  = LSARB_MAX_OUTST,
  parameter int unsigned StarveLim = 4,
  localparam int unsigned OutstW   = $clog2(MaxOutst + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              iss_valid_i,
  input  lsu_req_info_t     iss_req_i,
  output logic              iss_rdy_o,
  input  logic              cx_valid_i,
  input  logic              cx_lock_i,
  input  lsu_req_info_t     cx_req_i,
  output logic              cx_rdy_o,
  output logic              lsif_valid_o,
  output lsu_req_info_t     lsif_req_o,
  input  logic              lsif_rdy_i,
  input  logic              retire_i,
  output logic              grant_cx_o,
  output logic [OutstW-1:0] outst_o,
  output logic              cnt_err_o
);

  localparam int unsigned        StarveW   = $clog2(StarveLim + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(StarveLim);
  localparam logic [OutstW-1:0]  OutstMax  = OutstW'(MaxOutst);

  lsarb_state_e       state_q, state_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic [OutstW-1:0]  outst;
  logic               cnt_err;

  logic credit_ok;
  logic sel_cx;
  logic sel_valid;
  logic accept;
  logic cx_acc;
  logic iss_acc;

  // Selection and request mux. Nothing here looks at lsif_rdy_i except the
  // accept terms, so valid never depends on ready.
  always_comb begin
    credit_ok = (outst < OutstMax) & ~flush_i;

    sel_cx = 1'b0;
    case (state_q)
      ARB:     sel_cx = cx_valid_i & ~(iss_valid_i & (starve_q == StarveMax));
      LOCK:    sel_cx = 1'b1;
      default: sel_cx = 1'b0;
    endcase

    sel_valid    = sel_cx ? cx_valid_i : iss_valid_i;
    lsif_valid_o = sel_valid & credit_ok;

    lsif_req_o = NULL_LSU_REQ_INFO;
    if (sel_valid) lsif_req_o = sel_cx ? cx_req_i : iss_req_i;

    accept  = lsif_valid_o & lsif_rdy_i;
    cx_acc  = accept & sel_cx;
    iss_acc = accept & ~sel_cx;

    cx_rdy_o   = cx_acc;
    iss_rdy_o  = iss_acc;
    grant_cx_o = sel_cx;
  end

  // Next-state: lock tracking and the starvation counter.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (flush_i) begin
      state_d  = ARB;
      starve_d = '0;
    end else begin
      if (cx_acc) state_d = cx_lock_i ? LOCK : ARB;

      if (!iss_valid_i || iss_acc) begin
        starve_d = '0;
      end else if (cx_acc && (starve_q != StarveMax)) begin
        starve_d = starve_q + StarveW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ARB;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  credit_counter #(
    .MaxVal (MaxOutst)
  ) u_credit (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .inc_i  (accept),
    .dec_i  (retire_i),
    .cnt_o  (outst),
    .err_o  (cnt_err)
  );

  assign outst_o   = outst;
  assign cnt_err_o = cnt_err;

endmodule
